// File: rtl/viterbi_frame_sequencer.sv
// rtl/viterbi_frame_sequencer.sv - frames encoded symbols for the Viterbi core and returns its results
// Forwards trellis-table writes, sequences restart/enable, and guards the result wait with a timeout.
module viterbi_frame_sequencer #(
  parameter int N          = 2,
  parameter int K          = 1,
  parameter int M          = 4,
  parameter int L          = 7,
  parameter int EW         = $clog2(L*N)+1,
  parameter int ERR_THRESH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [M-K-1:0]   cfg_state,
  input  logic [K-1:0]     cfg_input,
  input  logic [M-K-1:0]   cfg_next,
  input  logic [N-1:0]     cfg_out,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [N-1:0]     sym_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [K*L-1:0]   res_decoded,
  output logic [EW-1:0]    res_error,
  output logic             res_bad,
  output logic             res_timeout,
  output logic             dec_reset,
  output logic             dec_restart,
  output logic             dec_enable,
  output logic             dec_load,
  output logic [N-1:0]     dec_encoded,
  output logic [M-K-1:0]   dec_state_address,
  output logic [K-1:0]     dec_input_address,
  output logic [M-K-1:0]   dec_next_state_data,
  output logic [N-1:0]     dec_output_data,
  input  logic [K*L-1:0]   dec_decoded,
  input  logic [EW-1:0]    dec_error,
  input  logic             dec_ready
);
  localparam int CW  = M + 1;
  localparam int SCW = $clog2(L + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CFG_FULL = CW'(2 ** M);
  localparam logic [SCW-1:0] SYM_LAST = SCW'(L - 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [EW-1:0]  THRESH   = EW'(ERR_THRESH);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RESTART, S_STREAM, S_WAIT, S_RESULT} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cfg_cnt;
  logic [SCW-1:0]  sym_cnt;
  logic [TW-1:0]   to_cnt;
  logic [N-1:0]    last_sym;
  logic [K*L-1:0]  res_decoded_q;
  logic [EW-1:0]   res_error_q;
  logic            res_bad_q;
  logic            res_timeout_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:    state_nx = S_IDLE;
      // a pending table write always wins over starting a frame
      S_IDLE:    if (!cfg_valid && sym_valid && cfg_cnt == CFG_FULL) state_nx = S_RESTART;
      S_RESTART: state_nx = S_STREAM;
      S_STREAM:  if (sym_valid && sym_cnt == SYM_LAST) state_nx = S_WAIT;
      S_WAIT:    if (dec_ready || to_cnt == TO_LAST) state_nx = S_RESULT;
      S_RESULT:  if (res_ready) state_nx = sym_valid ? S_RESTART : S_IDLE;
      default:   state_nx = S_INIT;
    endcase
  end

  always_comb begin
    cfg_ready           = 1'b0;
    sym_ready           = 1'b0;
    res_valid           = 1'b0;
    dec_reset           = 1'b0;
    dec_restart         = 1'b0;
    res_decoded         = '0;
    res_error           = '0;
    res_bad             = 1'b0;
    res_timeout         = 1'b0;
    dec_encoded         = '0;
    if (!reset) begin
      case (state)
        S_INIT:    dec_reset   = 1'b1;
        S_IDLE:    cfg_ready   = cfg_valid;
        S_RESTART: dec_restart = 1'b1;
        S_STREAM:  sym_ready   = sym_valid;
        S_RESULT:  res_valid   = 1'b1;
        default:   ;
      endcase
      res_decoded = res_decoded_q;
      res_error   = res_error_q;
      res_bad     = res_bad_q;
      res_timeout = res_timeout_q;
      // the core sees the previous symbol again while the stream is paused
      dec_encoded = sym_ready ? sym_data : last_sym;
    end
    dec_load            = cfg_ready;
    dec_enable          = sym_ready;
    dec_state_address   = cfg_ready ? cfg_state : '0;
    dec_input_address   = cfg_ready ? cfg_input : '0;
    dec_next_state_data = cfg_ready ? cfg_next  : '0;
    dec_output_data     = cfg_ready ? cfg_out   : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_cnt       <= '0;
      sym_cnt       <= '0;
      to_cnt        <= '0;
      last_sym      <= '0;
      res_decoded_q <= '0;
      res_error_q   <= '0;
      res_bad_q     <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      if (state == S_IDLE && cfg_valid && cfg_cnt != CFG_FULL) cfg_cnt <= cfg_cnt + 1'b1;
      case (state)
        S_RESTART: sym_cnt <= '0;
        S_STREAM: begin
          if (sym_valid) begin
            sym_cnt  <= sym_cnt + 1'b1;
            last_sym <= sym_data;
            if (sym_cnt == SYM_LAST) to_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (dec_ready) begin
            res_decoded_q <= dec_decoded;
            res_error_q   <= dec_error;
            res_bad_q     <= dec_error > THRESH;
            res_timeout_q <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LAST) begin
              res_decoded_q <= '0;
              res_error_q   <= '1;
              res_bad_q     <= 1'b1;
              res_timeout_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
